mpmc11_wr_burst_gen: RTL

MPMC11_WR_BURST_GEN -- requirements
Module: mpmc11_wr_burst_gen

---
 rtl/mpmc11_wr_burst_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mpmc11_wr_burst_gen.sv
// Write-burst generator: pairs each source data beat with one memory write command.
// MPMC11_WR_MASK_EN enables the byte mask from src_sel; otherwise every byte is written.
module mpmc11_wr_burst_gen #(
  parameter int INC_AMT = 32,
  parameter int DW      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [5:0]        burst_len,
  input  logic [31:0]       addr_base,
  input  logic              src_valid,
  input  logic [DW-1:0]     src_data,
  input  logic [DW/8-1:0]   src_sel,
  output logic              src_ready,
  input  logic              mem_wdf_rdy,
  output logic              mem_wdf_wren,
  output logic              mem_wdf_end,
  output logic [DW-1:0]     mem_wdf_data,
  output logic [DW/8-1:0]   mem_wdf_mask,
  input  logic              mem_rdy,
  output logic              mem_en,
  output logic [2:0]        mem_cmd,
  output logic [31:0]       mem_addr,
  output logic [5:0]        burst_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESET = 3'd1,
    WDATA  = 3'd2,
    WCMD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] len_q;
  logic       in_wdata;
  logic       unused_bits;

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every register so a reset mid-burst abandons it with no done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      mem_addr  <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state <= PRESET;
            len_q <= burst_len;
            busy  <= 1'b1;
          end
        end
        PRESET: begin
          state     <= WDATA;
          mem_addr  <= {addr_base[31:5], 5'h0};
          burst_cnt <= '0;
        end
        WDATA: begin
          if (src_valid && mem_wdf_rdy) begin
            state  <= WCMD;
            mem_en <= 1'b1;
          end
        end
        WCMD: begin
          if (mem_rdy) begin
            mem_addr  <= mem_addr + 32'(INC_AMT);
            burst_cnt <= burst_cnt + 6'd1;
            mem_en    <= 1'b0;
            // Compare before the increment so a 64-beat burst ends as the count wraps.
            if (burst_cnt == len_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WDATA;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

  // Data-path handshakes follow the inputs within the WDATA cycle, so they are
  // decoded from the registered state rather than registered themselves.
  assign in_wdata     = (state == WDATA);
  assign src_ready    = in_wdata & mem_wdf_rdy;
  assign mem_wdf_wren = in_wdata & src_valid;
  assign mem_wdf_end  = mem_wdf_wren;
  assign mem_wdf_data = src_data;
  assign mem_cmd      = 3'b000;

`ifdef MPMC11_WR_MASK_EN
  assign mem_wdf_mask = ~src_sel;
`else
  assign mem_wdf_mask = '0;
`endif

  // The command address is always beat aligned; low base bits never reach it.
  assign unused_bits = ^{addr_base[4:0], src_sel};

endmodule
